// File: rtl/digit_text_ctrl.sv
// Font-ROM sequencer for a fixed digit text window: ROM address generation, alignment
// to the ROM's registered read, pixel serialisation and frame-synchronous digit updates.
module digit_text_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8,
    parameter int GLYPH_H    = 16,
    parameter int NUM_DIGITS = 8,
    parameter int X0         = 100,
    parameter int Y0         = 200
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [10:0]             hcount,
    input  logic [10:0]             vcount,
    input  logic                    video_on,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    load,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [DATA_WIDTH-1:0]   rom_q,
    output logic                    pix,
    output logic                    pix_valid,
    output logic                    update_pending
);
    localparam int ROW_W = $clog2(GLYPH_H);
    localparam int COL_W = $clog2(DATA_WIDTH);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam logic [10:0]      X0_C     = 11'(X0);
    localparam logic [10:0]      X1_C     = 11'(X0 + DATA_WIDTH * NUM_DIGITS);
    localparam logic [10:0]      Y0_C     = 11'(Y0);
    localparam logic [10:0]      Y1_C     = 11'(Y0 + GLYPH_H);
    localparam logic [ROW_W-1:0] Y0_ROW   = ROW_W'(Y0);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIG_W-1:0]      active_q, active_d, pending_q, pending_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [COL_W-1:0]      col_q, col_d, col_now;
    logic [IDX_W-1:0]      idx_q, idx_d, idx_now;
    logic [3:0]            active_nib [NUM_DIGITS];
    logic [3:0]            code;
    logic [ROW_W-1:0]      row;
    logic                  win, blank, frame_start;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  win_p1_q, win_p2_q, blank_p1_q, blank_p2_q;
    logic [COL_W-1:0]      col_p1_q, col_p2_q;
    logic                  pix_q, pix_d, pix_valid_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign active_nib[gi] = active_q[4*(NUM_DIGITS-1-gi) +: 4];
        end
    endgenerate

    assign frame_start = (hcount == 11'd0) && (vcount == 11'd0);

    // A load coinciding with frame start bypasses the pending buffer entirely.
    always_comb begin
        active_d    = active_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        if (load) begin
            pending_d   = digits;
            pend_flag_d = 1'b1;
        end
        if (frame_start) begin
            if (load)
                active_d = digits;
            else if (pend_flag_q)
                active_d = pending_q;
            pend_flag_d = 1'b0;
        end
    end

    always_comb begin
        col_now = (hcount == X0_C) ? '0 : col_q;
        idx_now = (hcount == X0_C) ? '0 : idx_q;
        col_d   = (col_now == COL_LAST) ? '0 : col_now + COL_W'(1);
        idx_d   = idx_now;
        if (col_now == COL_LAST)
            idx_d = (idx_now == IDX_LAST) ? '0 : idx_now + IDX_W'(1);
    end

    always_comb begin
        win   = video_on && (hcount >= X0_C) && (hcount < X1_C)
                         && (vcount >= Y0_C) && (vcount < Y1_C);
        row   = vcount[ROW_W-1:0] - Y0_ROW;
        code  = active_nib[idx_now];
        blank = (code > 4'd9);
        rom_addr_d = rom_addr_q;
        if (win)
            rom_addr_d = blank ? '0
                       : ADDR_WIDTH'(code) * ADDR_WIDTH'(GLYPH_H) + ADDR_WIDTH'(row);
    end

    // rom_q already belongs to the sample carried in the *_p2 stage.
    assign pix_d = win_p2_q && !blank_p2_q && rom_q[COL_LAST - col_p2_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= '1;
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
            col_q       <= '0;
            idx_q       <= '0;
            rom_addr_q  <= '0;
            win_p1_q    <= 1'b0;
            blank_p1_q  <= 1'b0;
            col_p1_q    <= '0;
            win_p2_q    <= 1'b0;
            blank_p2_q  <= 1'b0;
            col_p2_q    <= '0;
            pix_q       <= 1'b0;
            pix_valid_q <= 1'b0;
        end else begin
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_flag_q <= pend_flag_d;
            col_q       <= col_d;
            idx_q       <= idx_d;
            rom_addr_q  <= rom_addr_d;
            win_p1_q    <= win;
            blank_p1_q  <= blank;
            col_p1_q    <= col_now;
            win_p2_q    <= win_p1_q;
            blank_p2_q  <= blank_p1_q;
            col_p2_q    <= col_p1_q;
            pix_q       <= pix_d;
            pix_valid_q <= win_p2_q;
        end
    end

    assign rom_addr       = rom_addr_q;
    assign pix            = pix_q;
    assign pix_valid      = pix_valid_q;
    assign update_pending = pend_flag_q;
endmodule

// File: doc/digit_text_ctrl.md
# digit_text_ctrl

Sequencing controller for the 160-entry character font ROM (10 glyphs × 16 rows × 12 pixels, digits 0–9, glyph row at address digit·16+row). It sits between the VGA timing generator and the font ROM. For every pixel of a fixed text window it computes the ROM address and absorbs the ROM's one-cycle registered read. It then serializes the returned glyph row into a 1-bit pixel stream aligned to a fixed pipeline latency. It also buffers host digit updates and applies them only at frame start, so the display never tears.

## Interface
- DATA_WIDTH, 12, glyph width in pixels; equals the font ROM word width
- ADDR_WIDTH, 8, font ROM address width
- GLYPH_H, 16, glyph height in rows; fixed power of two
- NUM_DIGITS, 8, number of digit cells in the window
- X0, 100, window left edge (hcount)
- Y0, 200, window top edge (vcount)
- clk  in  1  pixel clock; hcount advances by 1 per clk
- rst_n  in  1  asynchronous active-low reset
- hcount  in  11  current pixel column from the VGA timing generator
- vcount  in  11  current line from the VGA timing generator
- video_on  in  1  active display region
- digits  in  4·NUM_DIGITS  digit codes; most significant nibble is the leftmost cell; codes 10–15 are blank
- load  in  1  one-cycle strobe; captures digits into the pending register
- rom_addr  out  ADDR_WIDTH  font ROM read address; registered
- rom_q  in  DATA_WIDTH  font ROM data, valid one clk after rom_addr
- pix  out  1  rendered pixel, 1 = foreground
- pix_valid  out  1  pix belongs to the text window
- update_pending  out  1  pending digits not yet applied

## Operation
- Registers:
  - active[4·NUM_DIGITS]: the rendered digit codes. Reset value is all 0xF (blank).
  - pending[4·NUM_DIGITS]: buffered host update. Reset value is 0.
  - pend_flag: set when pending holds an unapplied update.
- load = 1: pending ← digits and pend_flag ← 1. The last load before frame start wins.
- Frame start is the cycle with hcount == 0 and vcount == 0:
  - If pend_flag = 1: active ← pending and pend_flag ← 0.
  - If load and frame start occur in the same cycle: active ← digits directly and pend_flag ends at 0.
- Window: X0 ≤ hcount < X0 + DATA_WIDTH·NUM_DIGITS, Y0 ≤ vcount < Y0 + GLYPH_H, and video_on = 1.
- Cell tracking uses counters, not division:
  - col counts 0..DATA_WIDTH−1 and idx counts 0..NUM_DIGITS−1.
  - Both load 0 in the cycle hcount == X0.
  - col increments every clk; at DATA_WIDTH−1 it wraps to 0 and idx increments.
  - Counter values outside the window are don't-care.
- Address generation:
  - row = vcount − Y0, taken as the low log2(GLYPH_H) bits.
  - code = active nibble for idx.
  - rom_addr ← code·GLYPH_H + row when code ≤ 9, otherwise 0.
  - rom_addr updates only in the window; it holds its last value outside.
- Pixel select: pix = rom_q[DATA_WIDTH−1−col_d], where col_d is col delayed to align with rom_q. Bit DATA_WIDTH−1 is the leftmost pixel.
- pix is forced to 0 when:
  - the delayed window flag is 0, or
  - the delayed blank flag is 1 (code > 9).
- update_pending = pend_flag.

## Timing
- Pipeline:
  - S0: hcount/vcount are sampled in cycle t.
  - S1: rom_addr is registered at edge t+1, along with win_d1, col_d1 and blank_d1.
  - ROM: rom_q is valid after edge t+2; win_d2, col_d2 and blank_d2 are registered.
  - S2: pix and pix_valid are registered at edge t+3.
- Fixed latency of 3 clk from coordinates to pix. Any VGA sync delay to match it lies outside this block.
- pix_valid = win_d2, registered, so it rises exactly 3 clk after the first window pixel.
- A frame-start digit swap affects pixels sampled from the following cycle onward. Because the window never contains (0,0), no glyph is ever mixed.
- Reset (asynchronous, any time, including mid-line): rom_addr = 0, pix = 0, pix_valid = 0, update_pending = 0, active = all 0xF, all delay stages = 0. After release, output resumes correctly from the next hcount == X0.
- No back-pressure; the ROM read is unconditional every clk.

## Test plan
- Reset then 2 frames with no load: pix_valid pulses 96 clk per window line for 16 lines; pix = 0 throughout, because active is blank.
- load digits = 0x1FFFFFFF, then a frame start:
  - On line Y0+3, rom_addr = 19 from X0+1 through X0+12.
  - pix equals the bits of ROM word 19, MSB first, starting at cycle X0+3.
  - Remaining cells give pix = 0.
- load digits = 0x98765432 mid-window:
  - Current frame output is unchanged and update_pending = 1.
  - After the next frame start, cell 0 row 0 gives rom_addr = 144 and update_pending = 0.
- Two loads in one frame (0x11111111 then 0x22222222): the next frame renders the 2 glyph only, at rom_addr 32..47.
- load with digits = 0x33333333 coincident with hcount = vcount = 0: active updates that cycle, update_pending stays 0, and the frame shows the 3 glyph (rom_addr 48+row).
- Assert rst_n low at hcount = X0+40 on line Y0+5: outputs go to 0 immediately, active returns to blank, and the next frame renders blank with pix_valid still correct.
